spike_packet_receiver: RTL and testbench

- Network-interface receive path at each mesh node, sitting between the router's local output port and the node's neuron core / synapse memory.
- It is the receiving end of the node's spike packetizer. It accepts single-flit spike packets and two-flit weight-write packets.
- It validates the destination, buffers spikes in a small FIFO for the core, and forwards weight writes over a valid/ready port.
- It keeps saturating error counters for misrouted and malformed packets.

---
 rtl/spike_packet_receiver_if.sv | 52 +++++
 rtl/spike_packet_receiver.sv | 221 ++++++++++++++++++++++
 tb/tb_spike_packet_receiver.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_packet_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : spike_packet_receiver_if
//  Description : Bundles the receive-path buses of spike_packet_receiver:
//                the router flit input, the spike FIFO head output, the
//                weight-write valid/ready port and the error counters.
//  Ports       : slave  - the receiver's view (flit sink, spike/wr source)
//                master - the surrounding logic's view (flit source, sinks)
//  Revision    : 1.0  initial release
// ============================================================================
interface spike_packet_receiver_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_NEURONS = 32,
    parameter int NID_W       = $clog2(NUM_NEURONS)
);
    // Router local output port -> receiver
    logic                  pkt_in_valid;
    logic [DATA_WIDTH-1:0] pkt_in_data;
    logic                  pkt_in_ready;

    // Spike FIFO head -> neuron core
    logic                  spike_valid;
    logic [NID_W-1:0]      spike_neuron_id;
    logic [3:0]            spike_src_row;
    logic [3:0]            spike_src_col;
    logic                  spike_ack;

    // Weight write -> synapse memory
    logic                  wr_valid;
    logic [13:0]           wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;

    // Saturating error counters
    logic [7:0]            err_misroute_cnt;
    logic [7:0]            err_bad_cnt;

    modport slave (
        input  pkt_in_valid, pkt_in_data, spike_ack, wr_ready,
        output pkt_in_ready, spike_valid, spike_neuron_id, spike_src_row,
               spike_src_col, wr_valid, wr_addr, wr_data,
               err_misroute_cnt, err_bad_cnt
    );

    modport master (
        output pkt_in_valid, pkt_in_data, spike_ack, wr_ready,
        input  pkt_in_ready, spike_valid, spike_neuron_id, spike_src_row,
               spike_src_col, wr_valid, wr_addr, wr_data,
               err_misroute_cnt, err_bad_cnt
    );
endinterface
`default_nettype wire

// File: rtl/spike_packet_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : spike_packet_receiver
//  Description : Network-interface receive path of a mesh node. Accepts
//                single-flit spike packets (queued in a small FIFO for the
//                neuron core) and two-flit weight-write packets (forwarded on
//                a valid/ready port). Misrouted and malformed packets are
//                dropped and counted in saturating 8-bit counters.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous reset, active low
//                bus  - spike_packet_receiver_if.slave (flit in, spike head
//                       out, weight write out, error counters out)
//  Revision    : 1.0  initial release
// ============================================================================
module spike_packet_receiver #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_NEURONS = 32,
    parameter int ROW_ID      = 0,
    parameter int COL_ID      = 0,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    spike_packet_receiver_if.slave        bus
);
    localparam int NID_W   = $clog2(NUM_NEURONS);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = 8 + NID_W;

    localparam logic [7:0] C_NODE_ID    = {4'(ROW_ID), 4'(COL_ID)};
    localparam logic [1:0] C_TYPE_SPIKE = 2'b00;
    localparam logic [1:0] C_TYPE_WHEAD = 2'b01;

    localparam logic [0:0] S_IDLE      = 1'b0;
    localparam logic [0:0] S_WAIT_DATA = 1'b1;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [0:0]            state_q, state_d;
    logic                  discard_q, discard_d;
    logic [13:0]           shadow_addr_q, shadow_addr_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [13:0]           wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [7:0]            mis_cnt_q, mis_cnt_d;
    logic [7:0]            bad_cnt_q, bad_cnt_d;
    logic [ENTRY_W-1:0]    fifo_mem_q [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Flit decode
    // ------------------------------------------------------------------
    logic [1:0]         w_type;
    logic               w_dst_match;
    logic [13:0]        w_payload;
    logic               w_id_legal;
    logic               w_accept;
    logic               w_ready;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_mis_inc;
    logic               w_bad_inc;
    logic [ENTRY_W-1:0] w_push_entry;
    logic [ENTRY_W-1:0] w_head;

    assign w_type       = bus.pkt_in_data[31:30];
    assign w_dst_match  = (bus.pkt_in_data[29:22] == C_NODE_ID);
    assign w_payload    = bus.pkt_in_data[13:0];
    // Neuron id must fit in NID_W bits; any higher payload bit is malformed.
    assign w_id_legal   = ((w_payload >> NID_W) == 14'd0);
    assign w_accept     = bus.pkt_in_valid && w_ready;
    assign w_fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign w_fifo_empty = (count_q == '0);
    assign w_pop        = bus.spike_ack && !w_fifo_empty;
    assign w_push_entry = {bus.pkt_in_data[21:14], w_payload[NID_W-1:0]};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (w_accept && (w_type == C_TYPE_WHEAD)) state_d = S_WAIT_DATA;
            S_WAIT_DATA: if (w_accept) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Ready is forced low while reset is held so no flit is
    // taken during reset; otherwise it depends only on registered state.
    // ------------------------------------------------------------------
    always_comb begin
        w_ready = 1'b0;
        if (rst) begin
            case (state_q)
                S_IDLE:      w_ready = !w_fifo_full;
                S_WAIT_DATA: w_ready = !wr_valid_q;
                default:     w_ready = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        discard_d     = discard_q;
        shadow_addr_d = shadow_addr_q;
        wr_valid_d    = wr_valid_q && !bus.wr_ready;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        w_push        = 1'b0;
        w_mis_inc     = 1'b0;
        w_bad_inc     = 1'b0;

        if (w_accept) begin
            if (state_q == S_IDLE) begin
                // Malformed checks take priority over the destination check.
                if (w_type[1]) begin
                    w_bad_inc = 1'b1;
                end else if (w_type == C_TYPE_WHEAD) begin
                    shadow_addr_d = w_payload;
                    discard_d     = !w_dst_match;
                    w_mis_inc     = !w_dst_match;
                end else if ((w_type == C_TYPE_SPIKE) && !w_id_legal) begin
                    w_bad_inc = 1'b1;
                end else if (!w_dst_match) begin
                    w_mis_inc = 1'b1;
                end else begin
                    w_push = 1'b1;
                end
            end else begin
                if (!discard_q) begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = shadow_addr_q;
                    wr_data_d  = bus.pkt_in_data;
                end
                discard_d = 1'b0;
            end
        end

        wr_ptr_d = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        mis_cnt_d = (w_mis_inc && (mis_cnt_q != 8'hFF)) ? mis_cnt_q + 8'd1 : mis_cnt_q;
        bad_cnt_d = (w_bad_inc && (bad_cnt_q != 8'hFF)) ? bad_cnt_q + 8'd1 : bad_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            discard_q     <= 1'b0;
            shadow_addr_q <= '0;
            wr_valid_q    <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            mis_cnt_q     <= '0;
            bad_cnt_q     <= '0;
        end else begin
            discard_q     <= discard_d;
            shadow_addr_q <= shadow_addr_d;
            wr_valid_q    <= wr_valid_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            mis_cnt_q     <= mis_cnt_d;
            bad_cnt_q     <= bad_cnt_d;
        end
    end

    // FIFO storage needs no reset: the head is masked whenever it is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= w_push_entry;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_head               = w_fifo_empty ? '0 : fifo_mem_q[rd_ptr_q];
    assign bus.pkt_in_ready     = w_ready;
    assign bus.spike_valid      = !w_fifo_empty;
    assign bus.spike_neuron_id  = w_head[NID_W-1:0];
    assign bus.spike_src_col    = w_head[NID_W+3:NID_W];
    assign bus.spike_src_row    = w_head[NID_W+7:NID_W+4];
    assign bus.wr_valid         = wr_valid_q;
    assign bus.wr_addr          = wr_addr_q;
    assign bus.wr_data          = wr_data_q;
    assign bus.err_misroute_cnt = mis_cnt_q;
    assign bus.err_bad_cnt      = bad_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_packet_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spike_packet_receiver
//  Description : Self-checking bench for spike_packet_receiver (node 1,1,
//                32 neurons, 4-entry FIFO). Expected spikes and weight writes
//                are queued as stimulus is issued; a monitor pops and compares
//                on every spike/weight handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spike_packet_receiver;
    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0] id;
        logic [3:0] row;
        logic [3:0] col;
    } spike_t;

    typedef struct packed {
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;

    spike_t spike_exp[$];
    wr_t    wr_exp[$];

    spike_packet_receiver_if #(.DATA_WIDTH(32), .NUM_NEURONS(32)) bus_if ();

    spike_packet_receiver #(
        .DATA_WIDTH (32),
        .NUM_NEURONS(32),
        .ROW_ID     (1),
        .COL_ID     (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] dr,
                                       input logic [3:0] dc, input logic [3:0] sr,
                                       input logic [3:0] sc, input logic [13:0] pl);
        return {t, dr, dc, sr, sc, pl};
    endfunction

    task automatic push_spike(input logic [4:0] id, input logic [3:0] r, input logic [3:0] c);
        spike_t s;
        s.id  = id;
        s.row = r;
        s.col = c;
        spike_exp.push_back(s);
    endtask

    task automatic push_wr(input logic [13:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wr_exp.push_back(w);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents a flit and returns 1 time unit after the edge that accepts it.
    task automatic send_flit(input logic [31:0] f);
        int n;
        n = 0;
        bus_if.pkt_in_valid = 1'b1;
        bus_if.pkt_in_data  = f;
        @(negedge clk);
        while (!bus_if.pkt_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: flit 0x%0h got no ready, required ready within 100 cycles", f);
        end
        @(posedge clk);
        #1;
        bus_if.pkt_in_valid = 1'b0;
    endtask

    // Scoreboard monitor: compares on each output handshake.
    always @(negedge clk) begin
        if (rst) begin
            if (bus_if.spike_valid && bus_if.spike_ack) begin
                if (spike_exp.size() == 0) begin
                    check("spike_unexpected", 32'(bus_if.spike_neuron_id), 32'hFFFF_FFFF);
                end else begin
                    spike_t e;
                    e = spike_exp.pop_front();
                    check("spike_id",  32'(bus_if.spike_neuron_id), 32'(e.id));
                    check("spike_row", 32'(bus_if.spike_src_row),   32'(e.row));
                    check("spike_col", 32'(bus_if.spike_src_col),   32'(e.col));
                end
            end
            if (bus_if.wr_valid && bus_if.wr_ready) begin
                if (wr_exp.size() == 0) begin
                    check("wr_unexpected", 32'(bus_if.wr_addr), 32'hFFFF_FFFF);
                end else begin
                    wr_t w;
                    w = wr_exp.pop_front();
                    check("wr_addr", 32'(bus_if.wr_addr), 32'(w.addr));
                    check("wr_data", bus_if.wr_data, w.data);
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"},       32'(bus_if.pkt_in_ready),     0);
        check({tag, "_spike_valid"}, 32'(bus_if.spike_valid),      0);
        check({tag, "_spike_id"},    32'(bus_if.spike_neuron_id),  0);
        check({tag, "_spike_row"},   32'(bus_if.spike_src_row),    0);
        check({tag, "_spike_col"},   32'(bus_if.spike_src_col),    0);
        check({tag, "_wr_valid"},    32'(bus_if.wr_valid),         0);
        check({tag, "_wr_addr"},     32'(bus_if.wr_addr),          0);
        check({tag, "_wr_data"},     bus_if.wr_data,               0);
        check({tag, "_mis_cnt"},     32'(bus_if.err_misroute_cnt), 0);
        check({tag, "_bad_cnt"},     32'(bus_if.err_bad_cnt),      0);
    endtask

    initial begin
        rst                 = 1'b0;
        bus_if.pkt_in_valid = 1'b0;
        bus_if.pkt_in_data  = '0;
        bus_if.spike_ack    = 1'b0;
        bus_if.wr_ready     = 1'b0;
        #3;
        check_outputs_zero("reset");
        tick(2);
        rst = 1'b1;
        tick(1);
        check("ready_after_reset", 32'(bus_if.pkt_in_ready), 1);

        // Routed spike: dst(1,1) src(0,2) id 7
        push_spike(5'd7, 4'd0, 4'd2);
        send_flit(mk(2'b00, 4'd1, 4'd1, 4'd0, 4'd2, 14'd7));
        check("spike_valid_next_cycle", 32'(bus_if.spike_valid), 1);
        check("spike_head_id", 32'(bus_if.spike_neuron_id), 7);
        bus_if.spike_ack = 1'b1;
        tick(1);
        bus_if.spike_ack = 1'b0;
        check("spike_valid_after_ack", 32'(bus_if.spike_valid), 0);

        // Fill FIFO, stall a fifth flit, then release with one ack
        for (int i = 0; i < 4; i++) begin
            push_spike(5'(10 + i), 4'd0, 4'd2);
            send_flit(mk(2'b00, 4'd1, 4'd1, 4'd0, 4'd2, 14'(10 + i)));
        end
        check("ready_low_when_full", 32'(bus_if.pkt_in_ready), 0);
        bus_if.pkt_in_valid = 1'b1;
        bus_if.pkt_in_data  = mk(2'b00, 4'd1, 4'd1, 4'd0, 4'd2, 14'd14);
        tick(3);
        check("ready_still_low_full", 32'(bus_if.pkt_in_ready), 0);
        push_spike(5'd14, 4'd0, 4'd2);
        bus_if.spike_ack = 1'b1;
        tick(1);
        bus_if.spike_ack = 1'b0;
        check("ready_after_one_ack", 32'(bus_if.pkt_in_ready), 1);
        send_flit(mk(2'b00, 4'd1, 4'd1, 4'd0, 4'd2, 14'd14));
        bus_if.spike_ack = 1'b1;
        tick(6);
        bus_if.spike_ack = 1'b0;
        check("fifo_drained", 32'(bus_if.spike_valid), 0);

        // Weight packet held by wr_ready=0
        bus_if.wr_ready = 1'b0;
        push_wr(14'h123, 32'hDEAD_BEEF);
        send_flit(mk(2'b01, 4'd1, 4'd1, 4'd0, 4'd0, 14'h123));
        check("whead_no_wr_valid", 32'(bus_if.wr_valid), 0);
        send_flit(32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            check("wr_valid_held", 32'(bus_if.wr_valid), 1);
            check("wr_addr_held",  32'(bus_if.wr_addr), 32'h123);
            check("wr_data_held",  bus_if.wr_data, 32'hDEAD_BEEF);
            tick(1);
        end
        push_wr(14'h0AB, 32'h1234_5678);
        send_flit(mk(2'b01, 4'd1, 4'd1, 4'd0, 4'd0, 14'h0AB));
        check("wr_addr_after_2nd_head", 32'(bus_if.wr_addr), 32'h123);
        bus_if.pkt_in_valid = 1'b1;
        bus_if.pkt_in_data  = 32'h1234_5678;
        tick(2);
        check("data_stalled_ready_low", 32'(bus_if.pkt_in_ready), 0);
        bus_if.wr_ready = 1'b1;
        send_flit(32'h1234_5678);
        check("wr2_valid", 32'(bus_if.wr_valid), 1);
        tick(1);
        bus_if.wr_ready = 1'b0;
        check("wr_valid_cleared", 32'(bus_if.wr_valid), 0);

        // Misrouted spike and misrouted weight packet
        send_flit(mk(2'b00, 4'd2, 4'd0, 4'd0, 4'd2, 14'd7));
        check("misroute_spike_cnt", 32'(bus_if.err_misroute_cnt), 1);
        check("misroute_spike_no_push", 32'(bus_if.spike_valid), 0);
        send_flit(mk(2'b01, 4'd2, 4'd0, 4'd0, 4'd0, 14'h055));
        check("misroute_whead_cnt", 32'(bus_if.err_misroute_cnt), 2);
        send_flit(32'hCAFE_F00D);
        check("discard_no_wr_valid", 32'(bus_if.wr_valid), 0);
        check("discard_back_idle_ready", 32'(bus_if.pkt_in_ready), 1);
        check("discard_bad_cnt", 32'(bus_if.err_bad_cnt), 0);
        push_spike(5'd5, 4'd0, 4'd2);
        send_flit(mk(2'b00, 4'd1, 4'd1, 4'd0, 4'd2, 14'd5));
        check("idle_after_discard_spike", 32'(bus_if.spike_valid), 1);
        check("idle_after_discard_no_wr", 32'(bus_if.wr_valid), 0);
        bus_if.spike_ack = 1'b1;
        tick(1);
        bus_if.spike_ack = 1'b0;

        // Malformed packets
        send_flit(32'hC000_0000);
        check("bad_reserved_cnt", 32'(bus_if.err_bad_cnt), 1);
        send_flit(mk(2'b00, 4'd1, 4'd1, 4'd0, 4'd2, 14'h0020));
        check("bad_payload_cnt", 32'(bus_if.err_bad_cnt), 2);
        check("bad_payload_no_push", 32'(bus_if.spike_valid), 0);
        send_flit(mk(2'b00, 4'd2, 4'd0, 4'd0, 4'd2, 14'h0020));
        check("bad_before_dst_cnt", 32'(bus_if.err_bad_cnt), 3);
        check("bad_before_dst_mis", 32'(bus_if.err_misroute_cnt), 2);
        for (int i = 0; i < 300; i++) begin
            send_flit((i % 2 == 0) ? 32'hC000_0000 : 32'h8000_0000);
        end
        check("bad_cnt_saturated", 32'(bus_if.err_bad_cnt), 255);
        check("mis_cnt_unchanged", 32'(bus_if.err_misroute_cnt), 2);

        // Reset between a weight head and its data, with two spikes queued
        send_flit(mk(2'b00, 4'd1, 4'd1, 4'd3, 4'd2, 14'd1));
        send_flit(mk(2'b00, 4'd1, 4'd1, 4'd3, 4'd2, 14'd2));
        send_flit(mk(2'b01, 4'd1, 4'd1, 4'd0, 4'd0, 14'h077));
        check("pre_reset_spike_valid", 32'(bus_if.spike_valid), 1);
        #1;
        rst = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        tick(2);
        rst = 1'b1;
        tick(1);
        check("post_reset_ready", 32'(bus_if.pkt_in_ready), 1);
        push_spike(5'd3, 4'd0, 4'd2);
        send_flit(mk(2'b00, 4'd1, 4'd1, 4'd0, 4'd2, 14'd3));
        check("post_reset_head_spike", 32'(bus_if.spike_valid), 1);
        check("post_reset_no_wr", 32'(bus_if.wr_valid), 0);
        bus_if.spike_ack = 1'b1;
        tick(1);
        bus_if.spike_ack = 1'b0;
        tick(2);

        check("sb_spike_remaining", 32'(spike_exp.size()), 0);
        check("sb_wr_remaining",    32'(wr_exp.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
